tx_packet_scheduler: RTL and testbench

// - Sequences the DDR-backed packet transmitter: queues packet descriptors (DDR start

---
 rtl/tx_sched_pkg.sv | 6 +
 rtl/desc_fifo.sv | 53 +++++
 rtl/tx_packet_scheduler.sv | 149 ++++++++++++++
 tb/tb_tx_packet_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and widths for the DDR packet transmit scheduler.
package tx_sched_pkg;
    localparam int DDR_ADDR_W = 25;

    typedef enum logic [2:0] {IDLE, LOAD, CMD_HI, WAIT, GAP} sched_state_t;
endpackage

// File: rtl/desc_fifo.sv
// Register-array FIFO holding packet descriptors (DDR start addresses).
module desc_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25
) (
    input  logic                     clk_original,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_original) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tx_packet_scheduler.sv
// Launches queued DDR packets toward the transmitter, tracks completion, gap and timeout.
//
// state  | meaning
// IDLE   | waiting for enable and a queued descriptor
// LOAD   | pop head descriptor into start_ram_addr
// CMD_HI | hold cmd_send high for CMD_PULSE cycles
// WAIT   | wait for eop handshake or timeout
// GAP    | enforce inter-packet idle time
module tx_packet_scheduler
    import tx_sched_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CMD_PULSE = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                    clk_original,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    repeat_mode,
    input  logic [15:0]             gap_cycles,
    input  logic                    desc_wr,
    input  logic [DDR_ADDR_W-1:0]   desc_addr,
    output logic                    desc_full,
    output logic [$clog2(DEPTH):0]  desc_count,
    output logic                    desc_drop,
    output logic                    cmd_send,
    output logic [DDR_ADDR_W-1:0]   start_ram_addr,
    input  logic                    tx_eop,
    input  logic                    tx_wren,
    input  logic                    tx_rdy,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    timeout_err,
    output logic [31:0]             sent_count
);
    localparam logic [15:0] PULSE_LD = 16'(CMD_PULSE - 1);
    localparam logic [15:0] TMO_LD   = 16'(TIMEOUT - 1);

    sched_state_t            state;
    sched_state_t            state_nxt;
    logic [15:0]             timer;
    logic [15:0]             timer_nxt;
    logic [15:0]             gap_load;
    logic                    complete;
    logic                    requeue;
    logic                    done_evt;
    logic                    tmo_evt;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic                    drop_nxt;
    logic [DDR_ADDR_W-1:0]   fifo_din;
    logic [DDR_ADDR_W-1:0]   fifo_dout;

    assign complete = tx_eop && tx_wren && tx_rdy;
    assign gap_load = (gap_cycles == 16'd0) ? 16'd0 : gap_cycles - 16'd1;
    assign cmd_send = (state == CMD_HI);
    assign busy     = (state != IDLE);

    // A completing descriptor in repeat mode owns the write port that cycle.
    assign fifo_push = requeue || (desc_wr && !desc_full);
    assign fifo_din  = requeue ? start_ram_addr : desc_addr;
    assign drop_nxt  = desc_wr && (requeue || desc_full);

    desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DDR_ADDR_W)
    ) u_desc_fifo (
        .clk_original (clk_original),
        .rst          (rst),
        .push         (fifo_push),
        .pop          (fifo_pop),
        .din          (fifo_din),
        .dout         (fifo_dout),
        .full         (desc_full),
        .empty        (fifo_empty),
        .count        (desc_count)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        fifo_pop  = 1'b0;
        requeue   = 1'b0;
        done_evt  = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) state_nxt = LOAD;
            end
            LOAD: begin
                fifo_pop  = 1'b1;
                timer_nxt = PULSE_LD;
                state_nxt = CMD_HI;
            end
            CMD_HI: begin
                if (timer == 16'd0) begin
                    timer_nxt = TMO_LD;
                    state_nxt = WAIT;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (complete) begin
                    done_evt  = 1'b1;
                    requeue   = repeat_mode;
                    timer_nxt = gap_load;
                    state_nxt = GAP;
                end else if (timer == 16'd0) begin
                    tmo_evt   = 1'b1;
                    timer_nxt = gap_load;
                    state_nxt = GAP;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            GAP: begin
                if (timer == 16'd0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            start_ram_addr <= '0;
            pkt_done       <= 1'b0;
            timeout_err    <= 1'b0;
            desc_drop      <= 1'b0;
            sent_count     <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            pkt_done    <= done_evt;
            timeout_err <= tmo_evt;
            desc_drop   <= drop_nxt;
            if (fifo_pop) start_ram_addr <= fifo_dout;
            if (done_evt) sent_count <= sent_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed self-checking bench for tx_packet_scheduler (TIMEOUT shortened to 100).
module tb_tx_packet_scheduler;
    logic        clk_original = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        repeat_mode = 1'b0;
    logic [15:0] gap_cycles = 16'd0;
    logic        desc_wr = 1'b0;
    logic [24:0] desc_addr = '0;
    logic        desc_full;
    logic [4:0]  desc_count;
    logic        desc_drop;
    logic        cmd_send;
    logic [24:0] start_ram_addr;
    logic        tx_eop = 1'b0;
    logic        tx_wren = 1'b0;
    logic        tx_rdy = 1'b1;
    logic        busy;
    logic        pkt_done;
    logic        timeout_err;
    logic [31:0] sent_count;

    tx_packet_scheduler #(.DEPTH(16), .CMD_PULSE(4), .TIMEOUT(100)) dut (
        .clk_original   (clk_original),
        .rst            (rst),
        .enable         (enable),
        .repeat_mode    (repeat_mode),
        .gap_cycles     (gap_cycles),
        .desc_wr        (desc_wr),
        .desc_addr      (desc_addr),
        .desc_full      (desc_full),
        .desc_count     (desc_count),
        .desc_drop      (desc_drop),
        .cmd_send       (cmd_send),
        .start_ram_addr (start_ram_addr),
        .tx_eop         (tx_eop),
        .tx_wren        (tx_wren),
        .tx_rdy         (tx_rdy),
        .busy           (busy),
        .pkt_done       (pkt_done),
        .timeout_err    (timeout_err),
        .sent_count     (sent_count)
    );

    always #5 clk_original = ~clk_original;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk_original) cyc++;

    // Passive monitor on the falling edge: launch log, pulse widths, event counts.
    logic        cmd_prev = 1'b0;
    int          hi_len = 0;
    int          last_len = 0;
    int          rise_cyc = 0;
    int          pd_cnt = 0;
    int          te_cnt = 0;
    logic [24:0] launch_q[$];

    always @(negedge clk_original) begin
        if (cmd_send && !cmd_prev) begin
            launch_q.push_back(start_ram_addr);
            rise_cyc = cyc;
            hi_len = 0;
        end
        if (cmd_send) hi_len++;
        if (!cmd_send && cmd_prev) last_len = hi_len;
        if (pkt_done) pd_cnt++;
        if (timeout_err) te_cnt++;
        cmd_prev = cmd_send;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_original);
        #1;
    endtask

    task automatic wait_cmd(input string tag, input logic val, input int lim, output int n);
        n = 0;
        while (cmd_send !== val && n < lim) begin
            tick();
            n++;
        end
        chk(tag, cmd_send, val);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < lim) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic push(input logic [24:0] a);
        desc_wr = 1'b1;
        desc_addr = a;
        tick();
        desc_wr = 1'b0;
    endtask

    task automatic drive_eop();
        tx_eop = 1'b1;
        tx_wren = 1'b1;
        tick();
        tx_eop = 1'b0;
        tx_wren = 1'b0;
    endtask

    localparam logic [24:0] A = 25'h0123456;
    localparam logic [24:0] B = 25'h0ABCDEF;
    localparam logic [24:0] C = 25'h1FFFFFF;

    initial begin
        int n;
        int comp_cyc;
        int pd_before;
        logic [24:0] exp_order [5];

        repeat (3) tick();
        chk("rst_async_cmd", cmd_send, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_cmd", cmd_send, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", desc_count, 5'd0);
        chk("rst_full", desc_full, 1'b0);
        chk("rst_addr", start_ram_addr, 25'd0);
        chk("rst_sent", sent_count, 32'd0);
        chk("rst_flags", {pkt_done, timeout_err, desc_drop}, 3'b000);

        // Single packet, gap 0
        enable = 1'b1;
        push(25'h0000100);
        chk("t1_count_after_push", desc_count, 5'd1);
        wait_cmd("t1_rise", 1'b1, 10, n);
        chk("t1_latency", n, 2);
        chk("t1_addr", start_ram_addr, 25'h0000100);
        chk("t1_popped", desc_count, 5'd0);
        wait_cmd("t1_fall", 1'b0, 10, n);
        chk("t1_pulse_len", last_len, 4);
        repeat (40) tick();
        drive_eop();
        chk("t1_pkt_done", pkt_done, 1'b1);
        wait_idle("t1_idle", 10);
        repeat (2) tick();
        chk("t1_pkt_done_count", pd_cnt, 1);
        chk("t1_sent", sent_count, 32'd1);
        chk("t1_no_timeout", te_cnt, 0);

        // Three packets in order with gap 10
        gap_cycles = 16'd10;
        launch_q.delete();
        push(A);
        push(B);
        push(C);
        comp_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            wait_cmd("t2_rise", 1'b1, 40, n);
            if (i > 0) chk("t2_gap_ok", (rise_cyc - comp_cyc) >= 13, 1'b1);
            wait_cmd("t2_fall", 1'b0, 10, n);
            repeat (5) tick();
            comp_cyc = cyc;
            drive_eop();
        end
        wait_idle("t2_idle", 40);
        chk("t2_nlaunch", launch_q.size(), 3);
        chk("t2_order0", launch_q[0], A);
        chk("t2_order1", launch_q[1], B);
        chk("t2_order2", launch_q[2], C);
        chk("t2_sent", sent_count, 32'd4);
        chk("t2_count", desc_count, 5'd0);

        // Repeat mode, enable dropped just before the fifth completion
        gap_cycles = 16'd2;
        repeat_mode = 1'b1;
        enable = 1'b0;
        launch_q.delete();
        push(A);
        push(B);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cmd("t3_rise", 1'b1, 40, n);
            chk("t3_count_at_launch", desc_count, 5'd1);
            wait_cmd("t3_fall", 1'b0, 10, n);
            repeat (3) tick();
            if (i == 4) enable = 1'b0;
            drive_eop();
            chk("t3_count_after_requeue", desc_count, 5'd2);
        end
        wait_idle("t3_idle", 20);
        repeat (5) tick();
        chk("t3_hold_idle", busy, 1'b0);
        exp_order[0] = A; exp_order[1] = B; exp_order[2] = A;
        exp_order[3] = B; exp_order[4] = A;
        chk("t3_nlaunch", launch_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("t3_order", launch_q[i], exp_order[i]);
        chk("t3_sent", sent_count, 32'd9);
        chk("t3_fifo_kept", desc_count, 5'd2);

        // Asynchronous reset while waiting for eop
        repeat_mode = 1'b0;
        gap_cycles = 16'd0;
        enable = 1'b1;
        wait_cmd("tr_rise", 1'b1, 10, n);
        wait_cmd("tr_fall", 1'b0, 10, n);
        repeat (10) tick();
        chk("tr_in_wait", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("tr_cmd", cmd_send, 1'b0);
        chk("tr_busy", busy, 1'b0);
        chk("tr_count", desc_count, 5'd0);
        chk("tr_sent", sent_count, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        push(25'h0000ABC);
        wait_cmd("tr_rise2", 1'b1, 10, n);
        chk("tr_latency2", n, 2);
        chk("tr_addr2", start_ram_addr, 25'h0000ABC);
        wait_cmd("tr_fall2", 1'b0, 10, n);
        repeat (20) tick();
        drive_eop();
        wait_idle("tr_idle2", 10);
        chk("tr_sent2", sent_count, 32'd1);

        // Fill the FIFO past DEPTH with the scheduler disabled
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            desc_wr = 1'b1;
            desc_addr = 25'h0000200 + 25'(i);
            tick();
            if (i == 14) begin
                chk("t4_not_full_15", desc_full, 1'b0);
                chk("t4_count_15", desc_count, 5'd15);
            end
            if (i == 15) begin
                chk("t4_full_16", desc_full, 1'b1);
                chk("t4_count_16", desc_count, 5'd16);
                chk("t4_no_drop_16", desc_drop, 1'b0);
            end
            if (i == 16) begin
                chk("t4_drop_17", desc_drop, 1'b1);
                chk("t4_count_17", desc_count, 5'd16);
            end
        end
        desc_wr = 1'b0;
        tick();
        chk("t4_drop_pulse", desc_drop, 1'b0);

        // Timeout: no eop, repeat on, bad descriptor must not come back
        repeat_mode = 1'b1;
        enable = 1'b1;
        pd_before = pd_cnt;
        wait_cmd("t5_rise", 1'b1, 10, n);
        chk("t5_addr", start_ram_addr, 25'h0000200);
        wait_cmd("t5_fall", 1'b0, 10, n);
        n = 0;
        while (timeout_err !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t5_timeout_delay", n, 100);
        chk("t5_sent_unchanged", sent_count, 32'd1);
        chk("t5_no_requeue", desc_count, 5'd15);
        wait_cmd("t5_next_rise", 1'b1, 20, n);
        chk("t5_next_addr", start_ram_addr, 25'h0000201);
        chk("t5_timeout_once", te_cnt, 1);
        // eop while still in CMD_HI must be ignored
        drive_eop();
        chk("t5_eop_in_cmd_ignored", pd_cnt, pd_before);
        chk("t5_still_busy", busy, 1'b1);
        wait_cmd("t5_next_fall", 1'b0, 10, n);
        repeat (3) tick();
        enable = 1'b0;
        desc_wr = 1'b1;
        desc_addr = 25'h00003FF;
        tx_eop = 1'b1;
        tx_wren = 1'b1;
        tick();
        desc_wr = 1'b0;
        tx_eop = 1'b0;
        tx_wren = 1'b0;
        chk("t5_requeue_beats_wr", desc_drop, 1'b1);
        chk("t5_count_requeue", desc_count, 5'd15);
        chk("t5_pkt_done", pkt_done, 1'b1);
        chk("t5_sent", sent_count, 32'd2);
        wait_idle("t5_idle", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
